// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and line/frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic        UART_IDLE_LEVEL = 1'b1;
  localparam int unsigned UART_DATA_BITS  = 8;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with occupancy count; pushes are refused when full, pops when empty.
module byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered 8N1 UART transmitter fed through a byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_buffered_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 19200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        busy,
  output logic                        txd
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

  tx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d;
  logic                      txd_d;
  logic                      busy_d;
  logic                      pop_c;
  logic                      bit_end;
  logic                      start_frame;
  logic [7:0]                fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  assign wr_ready = !fifo_full;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .pop   (pop_c),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign bit_end     = (cnt_q == CNT_W'(DIV - 1));
  // A frame begins from idle, or straight out of a finished stop bit.
  assign start_frame = !fifo_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop_c   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP:  if (bit_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      pop_c   = 1'b1;
      sh_d    = fifo_dout;
      cnt_d   = '0;
      idx_d   = '0;
      state_d = ST_START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_dout;
`endif
    end

    // Line value tracks the state being entered so txd stays a plain register.
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_d;
`endif
      default:  txd_d = UART_IDLE_LEVEL;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd     <= UART_IDLE_LEVEL;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd     <= txd_d;
      busy    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Directed self-checking bench for uart_buffered_tx (DIV = 16, 4-entry FIFO).
// Honours UART_TX_PARITY_EN to expect the extra parity bit period.
module tb_uart_buffered_tx;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [2:0] level;
  logic       busy;
  logic       txd;

  int n_cmp = 0;
  int n_err = 0;

  uart_buffered_tx #(
    .CLK_HZ     (16),
    .BAUD       (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .level    (level),
    .busy     (busy),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects a whole frame starting on the next cycle; each bit must hold for DIV cycles.
  task automatic check_frame(input logic [7:0] d, input string tag);
    logic [10:0] bits;
    logic        seen;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[9]  = ^d;
    bits[10] = 1'b1;
`else
    bits[9]  = 1'b1;
    bits[10] = 1'b1;
`endif
    for (int k = 0; k < NBITS; k++) begin
      seen = bits[k];
      for (int j = 0; j < DIV; j++) begin
        tick();
        if (txd !== bits[k]) seen = txd;
      end
      check($sformatf("%s bit%0d", tag, k), 32'(seen), 32'(bits[k]));
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    #2;
    check("rst txd", 32'(txd), 32'd1);
    check("rst level", 32'(level), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready", 32'(wr_ready), 32'd1);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single byte
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    tick();
    wr_valid = 1'b0;
    check("single level", 32'(level), 32'd1);
    check("single txd pre", 32'(txd), 32'd1);
    check("single busy pre", 32'(busy), 32'd0);
    check_frame(8'hA5, "A5");
    tick();
    check("single busy post", 32'(busy), 32'd0);
    check("single txd post", 32'(txd), 32'd1);
    check("single level post", 32'(level), 32'd0);
    repeat (3) tick();

    // Back-to-back
    wr_valid = 1'b1;
    wr_data  = 8'h31;
    fork
      begin
        tick();
        wr_data = 8'h32;
        tick();
        check("b2b level1", 32'(level), 32'd1);
        wr_data = 8'h33;
        tick();
        check("b2b level2", 32'(level), 32'd2);
        wr_valid = 1'b0;
      end
      begin
        tick();
        check_frame(8'h31, "b2b31");
        check_frame(8'h32, "b2b32");
        check_frame(8'h33, "b2b33");
      end
    join
    tick();
    check("b2b busy post", 32'(busy), 32'd0);
    repeat (3) tick();

    // Full FIFO
    fork
      begin
        int   d;
        int   cyc;
        logic rdy;
        d   = 0;
        cyc = 0;
        wr_valid = 1'b1;
        while (d < 8 && cyc < 3000) begin
          wr_data = 8'(d);
          rdy = wr_ready;
          tick();
          cyc++;
          if (rdy) d++;
          if (cyc == 5) begin
            check("full accepted", 32'(d), 32'd5);
            check("full ready", 32'(wr_ready), 32'd0);
            check("full level", 32'(level), 32'd4);
          end
          if (cyc == 6) check("full hold", 32'(d), 32'd5);
          if (cyc == FRAME + 2) begin
            check("full pop level", 32'(level), 32'd3);
            check("full pop ready", 32'(wr_ready), 32'd1);
          end
          if (cyc == FRAME + 3) check("full refill", 32'(d), 32'd6);
        end
        wr_valid = 1'b0;
        check("full all accepted", 32'(d), 32'd8);
      end
      begin
        tick();
        for (int i = 0; i < 8; i++) check_frame(8'(i), $sformatf("full%0d", i));
      end
    join
    tick();
    check("full busy post", 32'(busy), 32'd0);
    check("full level post", 32'(level), 32'd0);
    repeat (3) tick();

    // Reset mid-frame
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    tick();
    wr_data = 8'h11;
    tick();
    wr_data = 8'h22;
    tick();
    wr_valid = 1'b0;
    repeat (68) tick();
    check("mid txd", 32'(txd), 32'd1);
    check("mid busy", 32'(busy), 32'd1);
    check("mid level", 32'(level), 32'd2);
    rst = 1'b1;
    #1;
    check("arst txd", 32'(txd), 32'd1);
    check("arst level", 32'(level), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst ready", 32'(wr_ready), 32'd1);
    repeat (2) tick();
    rst = 1'b0;
    begin
      logic seen_t;
      logic seen_b;
      seen_t = 1'b1;
      seen_b = 1'b0;
      repeat (200) begin
        tick();
        if (txd !== 1'b1) seen_t = txd;
        if (busy !== 1'b0) seen_b = busy;
      end
      check("post rst idle txd", 32'(seen_t), 32'd1);
      check("post rst idle busy", 32'(seen_b), 32'd0);
    end

`ifdef UART_TX_PARITY_EN
    wr_valid = 1'b1;
    wr_data  = 8'h07;
    tick();
    wr_valid = 1'b0;
    check_frame(8'h07, "par07");
    tick();
    wr_valid = 1'b1;
    wr_data  = 8'h03;
    tick();
    wr_valid = 1'b0;
    check_frame(8'h03, "par03");
    tick();
    check("par busy post", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_buffered_tx.md
# uart_buffered_tx

Buffered 8N1 UART transmitter: the transmit-side counterpart to the calculator's byte receiver, so result and status bytes go back to the host without the caller waiting on each frame. Bytes are pushed through a valid/ready handshake into an internal FIFO and serialized LSB-first on `txd` at a baud rate derived from the system clock. It sits between `calculator_fsm`-style producers and the board's TX pin. It runs directly on the system clock, with no divided clock.

## Interface
- `CLK_HZ`, default 100000000: system clock frequency in Hz.
- `BAUD`, default 19200: line rate; bit period `DIV = CLK_HZ/BAUD` cycles, integer division, and `DIV` must be ≥ 2.
- `FIFO_DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `wr_valid` in 1: producer offers `wr_data`.
- `wr_data` in 8: byte to transmit.
- `wr_ready` out 1: FIFO can accept a byte; equals `!full`.
- `level` out $clog2(FIFO_DEPTH)+1: bytes currently in the FIFO, excluding the byte being shifted.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `txd` out 1: serial line, registered, idles high.

## Operation
- **Push:** a byte is accepted on a rising edge with `wr_valid && wr_ready`.
  - When the FIFO is full, `wr_ready` is 0 and the byte is not accepted, even if a pop happens on the same edge.
  - A push and a pop on the same edge leave `level` unchanged.
- **FSM states:** IDLE, START, DATA, PARITY (only when parity is compiled in), STOP.
- **IDLE:** if the FIFO is non-empty, pop the head into the shift register, clear the baud counter and bit index, and go to START. Otherwise stay, with `txd` = 1.
- **Bit period:** in every non-IDLE state `txd` is held for exactly `DIV` cycles. The baud counter runs 0..DIV-1, and the state or bit advances on the edge where the counter equals DIV-1.
- **START:** `txd` = 0.
- **DATA:** `txd` = shift register bit 0, shifting right once per bit period. After 8 bits (bit index 7 complete), go to PARITY or STOP.
- **STOP:** `txd` = 1 for one bit period. At the end of it, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- **FIFO arithmetic:** read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Full is `level == FIFO_DEPTH`; empty is `level == 0`.
- **Reset** (at any time, including mid-frame):
  - FSM goes to IDLE and the FIFO empties.
  - `txd` = 1, `wr_ready` = 1, `level` = 0, `busy` = 0.
  - A partial frame is abandoned. No resume.

## Timing
- A byte accepted on edge N into an empty FIFO while the FSM is idle is popped on edge N+1, and `txd` falls on edge N+1.
- `busy` rises on the same edge N+1.
- Frame length is 10·DIV cycles, or 11·DIV with parity.
- Back-to-back frames are contiguous: the next start bit begins on the edge after the last stop-bit cycle.
- `wr_ready` and `level` update on the edge following a push or pop. `wr_ready` is combinational from the full flag.
- `busy` falls on the edge that returns the FSM to IDLE.

## Configuration
- `UART_TX_PARITY_EN`:
  - **Defined:** a PARITY state is inserted between DATA and STOP. It transmits an even-parity bit for one bit period: the XOR of the 8 data bits, so that the total number of ones is even.
  - **Undefined:** pure 8N1, and the PARITY state and its logic do not exist.

## Structure
- **Shared package `uart_pkg`:**
  - the FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits);
  - `UART_IDLE_LEVEL` = 1'b1;
  - `UART_DATA_BITS` = 8.
- **Sub-module `byte_fifo`:** a synchronous FIFO with push/pop/full/empty/level, parameterized by depth.
- **Top level:** the FSM, the baud counter, the shift register and the `txd` register.

## Test plan
All cases use `CLK_HZ`=16 and `BAUD`=1, so `DIV`=16.
- **Single byte:** push 0xA5 from idle → `txd` = 0,1,0,1,0,0,1,0,1,1, each bit held exactly 16 cycles. The falling edge is 1 cycle after the accept. Then `busy` = 0.
- **Back-to-back:** push 0x31, 0x32, 0x33 on consecutive cycles → 30 contiguous bit periods (480 cycles) with no high gap between a stop bit and the next start bit. Bytes are received in order.
- **Full FIFO** (`FIFO_DEPTH`=4): hold `wr_valid` high with 0x00..0x07 from idle.
  - 5 bytes are accepted (1 shifting plus 4 queued).
  - `wr_ready` = 0 while `level` = 4.
  - Further bytes are accepted only after each pop.
  - No byte is lost or duplicated.
- **Reset mid-frame:** assert `rst` during bit 3 of 0xFF with 2 bytes queued →
  - immediately `txd` = 1, `level` = 0, `busy` = 0;
  - after release, the line stays idle high.
- **Parity** (`UART_TX_PARITY_EN` defined):
  - 0x07 → parity bit 1, frame of 11 bit periods;
  - 0x03 → parity bit 0.
